// File: rtl/system_pio_poll_pkg.sv
// Shared types and defaults for the PIO poll master.
package system_pio_poll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2,
        RESP = 2'd3
    } poll_state_t;

    localparam int DEF_ADDR_W      = 2;
    localparam int DEF_POLL_ADDR   = 0;
    localparam int DEF_PORT_W      = 6;
    localparam int DEF_PERIOD_W    = 16;
    localparam int DEF_TIMEOUT_CYC = 255;
    localparam int READDATA_W      = 32;

    // Down-counter reload for a poll period; a period of 0 behaves as 1.
    function automatic logic [31:0] period_reload(input logic [31:0] period);
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/system_pio_poll_master_if.sv
// Avalon-MM read-only master bus bundle used by the poll master.
interface system_pio_poll_master_if
    import system_pio_poll_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0]     avm_address;
    logic                  avm_read;
    logic                  avm_waitrequest;
    logic [READDATA_W-1:0] avm_readdata;
    logic                  avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/system_poll_timer.sv
// Loadable down-counter with a zero flag; holds at zero.
module system_poll_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/system_pio_poll_master.sv
// Avalon-MM poll master: periodically reads a PIO data register and
// publishes the low PORT_W bits with valid and change strobes.
// Optional build macro POLL_TIMEOUT_EN adds a response timeout and the
// timeout strobe port.
//
// state | meaning
// IDLE  | polling stopped, waiting for enable
// WAIT  | counting down the poll period
// REQ   | avm_read asserted, waiting for the slave to accept
// RESP  | read accepted, waiting for readdatavalid
module system_pio_poll_master
    import system_pio_poll_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int POLL_ADDR   = DEF_POLL_ADDR,
    parameter int PORT_W      = DEF_PORT_W,
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [PERIOD_W-1:0]           poll_period,
    system_pio_poll_master_if.master      bus,
    output logic [PORT_W-1:0]             data_out,
    output logic                          data_valid,
    output logic                          change_pulse
`ifdef POLL_TIMEOUT_EN
    ,
    output logic                          timeout
`endif
);

    poll_state_t         state;
    poll_state_t         state_next;
    logic                per_load;
    logic                per_dec;
    logic                per_zero;
    logic [PERIOD_W-1:0] per_reload;
    logic                capture;
    logic                done;
    logic                first_done;
    logic [PORT_W-1:0]   new_data;
    logic                unused_readdata;

`ifdef POLL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    logic to_load;
    logic to_dec;
    logic to_zero;
    logic abort;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    assign per_reload      = PERIOD_W'(period_reload(32'(poll_period)));
    assign new_data        = bus.avm_readdata[PORT_W-1:0];
    assign unused_readdata = ^bus.avm_readdata[READDATA_W-1:PORT_W];

    // avm_read is decoded from the registered state so it cannot drop
    // while the slave is stalling.
    assign bus.avm_read    = (state == REQ);
    assign bus.avm_address = bus.avm_read ? ADDR_W'(POLL_ADDR) : '0;

    system_poll_timer #(.W(PERIOD_W)) u_period_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (per_load),
        .load_value (per_reload),
        .dec        (per_dec),
        .zero       (per_zero)
    );

`ifdef POLL_TIMEOUT_EN
    // Loaded at acceptance so RESP lasts at most TIMEOUT_CYC cycles.
    system_poll_timer #(.W(TO_W)) u_timeout_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (to_load),
        .load_value (TO_W'(TIMEOUT_CYC - 1)),
        .dec        (to_dec),
        .zero       (to_zero)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and timer control.
    always_comb begin
        state_next = state;
        per_load   = 1'b0;
        per_dec    = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
`ifdef POLL_TIMEOUT_EN
        to_load    = 1'b0;
        to_dec     = 1'b0;
        abort      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (enable) begin
                    per_load   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (per_zero) begin
                    state_next = REQ;
                end else begin
                    per_dec = 1'b1;
                end
            end
            REQ: begin
                if (!bus.avm_waitrequest) begin
`ifdef POLL_TIMEOUT_EN
                    to_load    = 1'b1;
`endif
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.avm_readdatavalid) begin
                    capture = 1'b1;
                    done    = 1'b1;
`ifdef POLL_TIMEOUT_EN
                end else if (to_zero) begin
                    abort = 1'b1;
                    done  = 1'b1;
                end else begin
                    to_dec = 1'b1;
`endif
                end
                if (done) begin
                    if (enable) begin
                        per_load   = 1'b1;
                        state_next = WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture register and strobes; the first capture after reset always
    // reports a change.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out     <= '0;
            data_valid   <= 1'b0;
            change_pulse <= 1'b0;
            first_done   <= 1'b0;
        end else begin
            data_valid   <= capture;
            change_pulse <= capture && (!first_done || (new_data != data_out));
            if (capture) begin
                data_out   <= new_data;
                first_done <= 1'b1;
            end
        end
    end

`ifdef POLL_TIMEOUT_EN
    // One-cycle strobe after a read is abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= abort;
        end
    end
`endif

endmodule

// File: tb/tb_system_pio_poll_master.sv
// Directed bench for system_pio_poll_master with a simple Avalon slave model
// (configurable stall and response latency).
module tb_system_pio_poll_master;
    import system_pio_poll_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] poll_period;
    logic [5:0]  data_out;
    logic        data_valid;
    logic        change_pulse;
`ifdef POLL_TIMEOUT_EN
    logic        timeout;
`endif

    system_pio_poll_master_if #(.ADDR_W(2)) bus ();

    system_pio_poll_master #(
        .ADDR_W      (2),
        .POLL_ADDR   (0),
        .PORT_W      (6),
        .PERIOD_W    (16)
`ifdef POLL_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .poll_period  (poll_period),
        .bus          (bus),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .change_pulse (change_pulse)
`ifdef POLL_TIMEOUT_EN
        ,
        .timeout      (timeout)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model configuration.
    logic [5:0] in_port    = 6'h00;
    int         stall_cfg  = 0;
    int         lat_cfg    = 1;
    bit         respond_en = 1'b1;
    int         wait_left  = 0;
    int         resp_cnt   = 0;
    int         accepts    = 0;

    // Slave: drives its inputs shortly after each rising edge.
    initial begin
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            bus.avm_readdatavalid = (resp_cnt == 1) && respond_en;
            bus.avm_readdata = {26'h2AAAAAA, (resp_cnt == 1) ? in_port : ~in_port};
            if (resp_cnt > 0) resp_cnt--;
            if (bus.avm_read) begin
                if (wait_left > 0) begin
                    bus.avm_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    accepts++;
                    resp_cnt  = lat_cfg;
                    wait_left = stall_cfg;
                end
            end else begin
                bus.avm_waitrequest = 1'b0;
                wait_left = stall_cfg;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait expired", name);
    endtask

    task automatic wait_dv(input string name, output int t);
        t = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (data_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) expire(name);
    endtask

    task automatic wait_read(input string name, input logic level, output int t);
        t = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.avm_read === level) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) expire(name);
    endtask

    typedef struct {
        int         period;
        logic [5:0] in_val;
        int         stall;
        int         lat;
        logic       chg;
        int         gap;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ta, tb2, tr, t0, t1, len;
        bit addr_ok, strobe_seen, data_nz;
        int acc0, reads;

        // period, data, stall, latency, change on first capture, capture gap
        vecs[0] = '{4,  6'h15, 0, 1, 1'b1, 6};
        vecs[1] = '{4,  6'h15, 0, 1, 1'b0, 6};
        vecs[2] = '{4,  6'h2A, 0, 1, 1'b1, 6};
        vecs[3] = '{0,  6'h2A, 0, 1, 1'b0, 3};
        vecs[4] = '{1,  6'h07, 3, 2, 1'b1, 7};
        vecs[5] = '{10, 6'h07, 1, 4, 1'b0, 16};
        vecs[6] = '{2,  6'h3F, 0, 1, 1'b1, 4};

        reset = 1'b1;
        enable = 1'b0;
        poll_period = 16'd4;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_change", 32'(change_pulse), 32'h0);
        check("rst_read", 32'(bus.avm_read), 32'h0);
        check("rst_address", 32'(bus.avm_address), 32'h0);
`ifdef POLL_TIMEOUT_EN
        check("rst_timeout", 32'(timeout), 32'h0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            poll_period = 16'(vecs[i].period);
            in_port     = vecs[i].in_val;
            stall_cfg   = vecs[i].stall;
            lat_cfg     = vecs[i].lat;
            if (i == 0) enable = 1'b1;
            wait_dv($sformatf("v%0d_first_capture", i), ta);
            check($sformatf("v%0d_data_a", i), 32'(data_out), 32'(vecs[i].in_val));
            check($sformatf("v%0d_change_a", i), 32'(change_pulse), 32'(vecs[i].chg));
            wait_dv($sformatf("v%0d_second_capture", i), tb2);
            check($sformatf("v%0d_data_b", i), 32'(data_out), 32'(vecs[i].in_val));
            check($sformatf("v%0d_change_b", i), 32'(change_pulse), 32'h0);
            if (ta >= 0 && tb2 >= 0)
                check($sformatf("v%0d_gap", i), 32'(tb2 - ta), 32'(vecs[i].gap));
        end

        // Stalled request: read and address held for stall+1 cycles.
        poll_period = 16'd2;
        stall_cfg   = 3;
        lat_cfg     = 1;
        acc0        = accepts;
        wait_read("stall_rise", 1'b1, tr);
        len = 0;
        addr_ok = 1'b1;
        while (bus.avm_read === 1'b1 && len < 20) begin
            if (bus.avm_address !== 2'd0) addr_ok = 1'b0;
            len++;
            @(negedge clk);
        end
        check("stall_read_len", 32'(len), 32'd4);
        check("stall_addr_stable", 32'(addr_ok), 32'd1);
        wait_dv("stall_capture", ta);
        check("stall_one_accept", 32'(accepts - acc0), 32'd1);
        check("stall_data", 32'(data_out), 32'h3F);

        // Enable dropped while the read is in flight.
        stall_cfg = 0;
        lat_cfg   = 3;
        in_port   = 6'h11;
        wait_read("dis_rise", 1'b1, tr);
        wait_read("dis_fall", 1'b0, tr);
        enable = 1'b0;
        wait_dv("dis_capture", ta);
        check("dis_data", 32'(data_out), 32'h11);
        check("dis_change", 32'(change_pulse), 32'd1);
        reads = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.avm_read === 1'b1) reads++;
        end
        check("dis_no_reads", 32'(reads), 32'd0);

        // Reset during RESP; the late response must be ignored.
        in_port = 6'h3F;
        enable  = 1'b1;
        wait_read("rst_rise", 1'b1, tr);
        wait_read("rst_fall", 1'b0, tr);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_read_low", 32'(bus.avm_read), 32'd0);
        strobe_seen = 1'b0;
        data_nz = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (data_valid || change_pulse) strobe_seen = 1'b1;
            if (data_out != 6'h00) data_nz = 1'b1;
        end
        check("rst_late_no_strobe", 32'(strobe_seen), 32'd0);
        check("rst_late_data_zero", 32'(data_nz), 32'd0);
        wait_dv("rst_restart_capture", ta);
        check("rst_restart_data", 32'(data_out), 32'h3F);
        check("rst_restart_change", 32'(change_pulse), 32'd1);

`ifdef POLL_TIMEOUT_EN
        // Slave never answers: abort after 8 response cycles.
        respond_en = 1'b0;
        lat_cfg    = 1;
        wait_read("to_rise", 1'b1, t0);
        t1 = -1;
        strobe_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (data_valid) strobe_seen = 1'b1;
            if (timeout) begin
                t1 = cyc;
                break;
            end
        end
        if (t1 < 0) expire("to_pulse");
        else check("to_delay", 32'(t1 - t0), 32'd9);
        check("to_no_valid", 32'(strobe_seen), 32'd0);
        check("to_data_kept", 32'(data_out), 32'h3F);
        @(negedge clk);
        check("to_pulse_width", 32'(timeout), 32'd0);
        wait_read("to_next_read", 1'b1, tr);
        if (t0 >= 0 && tr >= 0) check("to_next_issue", 32'(tr - t0), 32'd11);
        respond_en = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
